dvs_ravens: RTL and testbench

DVS_RAVENS -- requirements
Module: dvs_ravens

---
 rtl/dvs_ravens.sv | 123 ++++++++++++
 tb/tb_dvs_ravens.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dvs_ravens.sv
// AER (address-event) receiver: 4-phase req/ack handshake, Y/X word decode, one-cycle RAVENS packet out.
// Optional macro DVS_RAVENS_BOUNDS_CHECK_EN suppresses packets for out-of-range coordinates.
`timescale 1ns/1ps

module dvs_ravens #(
  parameter int unsigned DVS_WIDTH_PXLS  = 320,
  parameter int unsigned DVS_HEIGHT_PXLS = 240,
  parameter int unsigned RAVENS_PKT_BITS = 32,
  parameter int unsigned CLK_PERIOD_NS   = 10,
  parameter int unsigned Y_SETTLE_NS     = 50
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 aer,
  input  logic                       xsel,
  input  logic                       req,
  output logic                       ack,
  output logic [RAVENS_PKT_BITS-1:0] ravens_pkt
);

  localparam int unsigned SETTLE_RAW    = (Y_SETTLE_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
  localparam int unsigned SETTLE_CYCLES = (SETTLE_RAW == 0) ? 1 : SETTLE_RAW;
  localparam int unsigned CNT_W         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // Coordinates arrive as 9-bit fields and the address lands in bits 12:5.
  generate
    if (DVS_WIDTH_PXLS > 512 || DVS_HEIGHT_PXLS > 512 || RAVENS_PKT_BITS < 13) begin : g_bad_geometry
      $error("dvs_ravens: unsupported geometry or packet width");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, Y_SETTLE, X_CAPTURE, WAIT_REQ_LOW} state_t;

  state_t                     state_reg, state_next;
  logic                       req_meta_reg, req_sync_reg;
  logic [8:0]                 y_reg, y_next;
  logic [CNT_W-1:0]           settle_cnt_reg, settle_cnt_next;
  logic                       ack_reg, ack_next;
  logic [RAVENS_PKT_BITS-1:0] pkt_reg, pkt_next, pkt_word;
  logic [8:0]                 x_word;
  logic [7:0]                 addr8;
  logic                       in_range;

  assign x_word = aer[9:1];
  // Only the low 8 bits of y*W + x are needed; 18-bit intermediate avoids overflow.
  assign addr8  = 8'(18'(y_reg) * 18'(DVS_WIDTH_PXLS) + 18'(x_word));

`ifdef DVS_RAVENS_BOUNDS_CHECK_EN
  assign in_range = (32'(x_word) < DVS_WIDTH_PXLS) && (32'(y_reg) < DVS_HEIGHT_PXLS);
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    pkt_word       = '0;
    pkt_word[12:5] = addr8;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta_reg   <= 1'b0;
      req_sync_reg   <= 1'b0;
      state_reg      <= IDLE;
      y_reg          <= '0;
      settle_cnt_reg <= '0;
      ack_reg        <= 1'b0;
      pkt_reg        <= '0;
    end else begin
      req_meta_reg   <= req;
      req_sync_reg   <= req_meta_reg;
      state_reg      <= state_next;
      y_reg          <= y_next;
      settle_cnt_reg <= settle_cnt_next;
      ack_reg        <= ack_next;
      pkt_reg        <= pkt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:         if (req_sync_reg) state_next = xsel ? X_CAPTURE : Y_SETTLE;
      Y_SETTLE: begin
        if (!req_sync_reg)                 state_next = IDLE;
        else if (settle_cnt_reg == CNT_LAST) state_next = WAIT_REQ_LOW;
      end
      X_CAPTURE:    state_next = WAIT_REQ_LOW;
      WAIT_REQ_LOW: if (!req_sync_reg) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_comb begin
    y_next          = y_reg;
    settle_cnt_next = '0;
    ack_next        = 1'b0;
    pkt_next        = '0;
    case (state_reg)
      Y_SETTLE: begin
        // A dropped req abandons the word: counter clears, no ack, y unchanged.
        if (req_sync_reg) begin
          if (settle_cnt_reg == CNT_LAST) begin
            y_next   = aer[8:0];
            ack_next = 1'b1;
          end else begin
            settle_cnt_next = settle_cnt_reg + 1'b1;
          end
        end
      end
      X_CAPTURE: begin
        ack_next = 1'b1;
        if (in_range) pkt_next = pkt_word;
      end
      WAIT_REQ_LOW: ack_next = req_sync_reg;
      default: ;
    endcase
  end

  assign ack        = ack_reg;
  assign ravens_pkt = pkt_reg;

endmodule

// File: tb/tb_dvs_ravens.sv
// Directed table-driven bench for dvs_ravens: Y/X handshakes, settle timing, abandon and reset corners.
`timescale 1ns/1ps

module tb_dvs_ravens;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  aer;
  logic        xsel;
  logic        req;
  logic        ack;
  logic [31:0] ravens_pkt;

  int          errors    = 0;
  int          checks    = 0;
  int          pkt_total = 0;
  int          ack_rises = 0;
  logic [31:0] last_pkt  = '0;
  realtime     ack_rise_t = 0.0;

  always #5 clk = ~clk;

  dvs_ravens dut (
    .clk        (clk),
    .rst        (rst),
    .aer        (aer),
    .xsel       (xsel),
    .req        (req),
    .ack        (ack),
    .ravens_pkt (ravens_pkt)
  );

  always @(negedge clk) begin
    if (ravens_pkt !== 32'h0) begin
      pkt_total++;
      last_pkt = ravens_pkt;
    end
  end

  always @(posedge ack) begin
    ack_rise_t = $realtime;
    ack_rises++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic handshake(input string tag, input logic xs, input logic [9:0] a,
                           input logic [31:0] exp_pkt, input int exp_cyc);
    int      base;
    realtime t_req;
    bit      got;
    @(negedge clk);
    xsel = xs;
    aer  = a;
    base = pkt_total;
    check({tag, "_idle_ack"}, 32'(ack), 32'd0);
    req   = 1'b1;
    t_req = $realtime;
    got   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; break; end
    end
    check({tag, "_ack_rise"}, 32'(got), 32'd1);
    if (got && !xs) check({tag, "_settle_ge_50ns"}, 32'(ack_rise_t - t_req >= 50.0), 32'd1);
    req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!ack) begin got = 1'b1; break; end
    end
    check({tag, "_ack_fall"}, 32'(got), 32'd1);
    repeat (3) @(negedge clk);
    aer = '0;
    check({tag, "_pkt_cycles"}, 32'(pkt_total - base), 32'(exp_cyc));
    if (exp_cyc > 0) check({tag, "_pkt_val"}, last_pkt, exp_pkt);
  endtask

  typedef struct {
    logic        xs;
    logic [9:0]  a;
    logic [31:0] exp_pkt;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int base;
    int rises;
    bit got;

    // X before any Y uses y=0; polarity bits set on some words to prove they are ignored.
    vecs[0]  = '{1'b1, {9'd10,  1'b0}, 32'h0000_0140, 1};
    vecs[1]  = '{1'b0, {1'b1,   9'd1}, 32'h0,         0};
    vecs[2]  = '{1'b1, {9'd2,   1'b0}, 32'h0000_0840, 1};
    vecs[3]  = '{1'b1, {9'd5,   1'b1}, 32'h0000_08A0, 1};
    vecs[4]  = '{1'b0, {1'b0, 9'd239}, 32'h0,         0};
    vecs[5]  = '{1'b1, {9'd319, 1'b0}, 32'h0000_1FE0, 1};
    vecs[6]  = '{1'b0, {1'b1,   9'd0}, 32'h0,         0};
    vecs[7]  = '{1'b1, {9'd300, 1'b1}, 32'h0000_0580, 1};
    vecs[8]  = '{1'b0, {1'b0,   9'd3}, 32'h0,         0};
    vecs[9]  = '{1'b1, {9'd7,   1'b0}, 32'h0000_18E0, 1};
`ifdef DVS_RAVENS_BOUNDS_CHECK_EN
    vecs[10] = '{1'b1, {9'd400, 1'b0}, 32'h0,         0};
`else
    vecs[10] = '{1'b1, {9'd400, 1'b0}, 32'h0000_0A00, 1};
`endif

    rst  = 1'b1;
    req  = 1'b0;
    xsel = 1'b0;
    aer  = '0;
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_pkt", ravens_pkt, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++)
      handshake($sformatf("vec%0d", i), vecs[i].xs, vecs[i].a, vecs[i].exp_pkt, vecs[i].exp_cyc);

    // Y word whose req drops mid-settle: no ack, y stays 3.
    @(negedge clk);
    rises = ack_rises;
    base  = pkt_total;
    xsel  = 1'b0;
    aer   = {1'b0, 9'd5};
    req   = 1'b1;
    repeat (4) @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    check("abandon_no_ack", 32'(ack_rises - rises), 32'd0);
    check("abandon_no_pkt", 32'(pkt_total - base), 32'd0);
    handshake("abandon_x1", 1'b1, {9'd1, 1'b0}, 32'h0000_1820, 1);

    // Reset pulsed while ack is high on an X word.
    @(negedge clk);
    xsel = 1'b1;
    aer  = {9'd2, 1'b0};
    req  = 1'b1;
    got  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (ack) begin got = 1'b1; break; end
    end
    check("rst_pre_ack", 32'(got), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_ack_drop", 32'(ack), 32'd0);
    check("rst_pkt_zero", ravens_pkt, 32'h0);
    @(negedge clk);
    req = 1'b0;
    aer = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    handshake("post_rst_x6", 1'b1, {9'd6, 1'b0}, 32'h0000_00C0, 1);
    handshake("post_rst_y1", 1'b0, {1'b0, 9'd1}, 32'h0,         0);
    handshake("post_rst_x2", 1'b1, {9'd2, 1'b0}, 32'h0000_0840, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
